// File: rtl/sdram_arbiter_pkg.sv
// Shared types and constants for the three-port SDRAM arbiter.
package sdram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0]  VID = 2'd0;
    localparam logic [1:0]  CPU = 2'd1;
    localparam logic [1:0]  AUD = 2'd2;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational winner selection: video first until it has hogged MAX_HOG
// contended grants, then round-robin between CPU and audio.
module sdram_arb_pick
    import sdram_arbiter_pkg::*;
#(
    parameter int MAX_HOG = 4,
    parameter int HOG_W   = 3
) (
    input  logic [2:0]       valid,
    input  logic [HOG_W-1:0] hog_cnt,
    input  logic [1:0]       rr,
    output logic [1:0]       winner,
    output logic             any
);

    logic others;
    logic vid_ok;

    always_comb begin
        others = valid[CPU] | valid[AUD];
        // Video may exceed its hog budget when nobody else is waiting.
        vid_ok = valid[VID] && ((32'(hog_cnt) < MAX_HOG) || !others);
        any    = |valid;
        winner = VID;
        if (vid_ok)
            winner = VID;
        else if (valid[CPU] && valid[AUD])
            winner = rr;
        else if (valid[CPU])
            winner = CPU;
        else if (valid[AUD])
            winner = AUD;
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Three-port (video/CPU/audio) arbiter in front of a single-command SDRAM
// controller, with bounded video hogging and a command timeout.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 26,
    parameter int MAX_HOG = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [2:0]          m_valid,
    input  logic [3*ADDR_W-1:0] m_addr,
    input  logic [95:0]         m_wdata,
    input  logic [11:0]         m_wstrb,
    output logic [2:0]          m_ready,
    output logic [31:0]         m_rdata,
    output logic [ADDR_W-1:0]   s_addr,
    output logic                s_we,
    output logic                s_oe,
    output logic [31:0]         s_din,
    output logic [3:0]          s_dqm,
    input  logic [31:0]         s_dout,
    input  logic                s_ready,
    input  logic                err_clr,
    output logic                err,
    output logic [1:0]          grant
);

    localparam int HOG_W = $clog2(MAX_HOG + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    state_t            state, state_nx;
    logic [HOG_W-1:0]  hog_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [1:0]        rr;
    logic [1:0]        winner;
    logic              any;
    logic              is_wr;
    logic              to_hit;
    logic              done;
    logic              others;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        sel_strb;

    sdram_arb_pick #(
        .MAX_HOG (MAX_HOG),
        .HOG_W   (HOG_W)
    ) u_pick (
        .valid   (m_valid),
        .hog_cnt (hog_cnt),
        .rr      (rr),
        .winner  (winner),
        .any     (any)
    );

    assign others    = m_valid[CPU] | m_valid[AUD];
    assign sel_addr  = m_addr[int'(winner)*ADDR_W +: ADDR_W];
    assign sel_wdata = m_wdata[int'(winner)*32 +: 32];
    assign sel_strb  = m_wstrb[int'(winner)*4 +: 4];

    // Timeout wins over a coincident s_ready: the command is already dropped.
    assign to_hit = (state == CMD) && (to_cnt == TO_W'(TIMEOUT));
    assign done   = (state == CMD) && (s_ready || to_hit);
    assign s_we   = (state == CMD) && is_wr && !to_hit;
    assign s_oe   = (state == CMD) && !is_wr && !to_hit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any) state_nx = CMD;
            CMD:     if (done) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_ready <= '0;
            m_rdata <= '0;
            s_addr  <= '0;
            s_din   <= '0;
            s_dqm   <= '0;
            is_wr   <= 1'b0;
            grant   <= VID;
            hog_cnt <= '0;
            rr      <= CPU;
            to_cnt  <= '0;
        end else begin
            m_ready <= '0;
            if (state == IDLE && any) begin
                grant  <= winner;
                s_addr <= sel_addr;
                s_din  <= sel_wdata;
                is_wr  <= |sel_strb;
                s_dqm  <= (|sel_strb) ? ~sel_strb : 4'b0000;
                to_cnt <= '0;
                if (winner == VID) begin
                    if (others && hog_cnt != HOG_W'(MAX_HOG))
                        hog_cnt <= hog_cnt + 1'b1;
                end else begin
                    hog_cnt <= '0;
                    rr      <= (winner == CPU) ? AUD : CPU;
                end
            end
            if (state == CMD) begin
                if (to_hit) begin
                    m_rdata <= TIMEOUT_RDATA;
                    m_ready <= 3'b001 << grant;
                end else if (s_ready) begin
                    if (!is_wr)
                        m_rdata <= s_dout;
                    m_ready <= 3'b001 << grant;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            err <= 1'b0;
        else if (to_hit)
            err <= 1'b1;
        else if (err_clr)
            err <= 1'b0;
    end

endmodule
